// File: rtl/test_status_device_pkg.sv
// Shared types and constants for the tohost status responder.
// State encoding, status-register bit positions, pass code, default address.
package test_status_device_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam int STAT_DONE    = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_FAIL    = 2;
  localparam int STAT_TIMEOUT = 3;

  localparam logic [31:0] PASS_CODE   = 32'h1;
  localparam logic [31:0] TOHOST_DFLT = 32'h0000_1000;

endpackage

// File: rtl/test_status_device_if.sv
// Request/response bus between the core (master) and the responder (slave).
// Ports: req_valid/ready/we/addr/wdata/wstrb, rsp_valid/rdata.
interface test_status_device_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/test_status_device_watchdog.sv
// Run-cycle counter with expiry pulse; holds its value when disabled.
// Ports: clk, rst (async low), i_en, o_expire, o_count.
module test_status_device_watchdog #(
  parameter logic [31:0] LIMIT = 32'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic        o_expire,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // The expiry cycle itself is not counted, so the
  // count freezes at LIMIT-1 on a timeout.
  assign o_expire = (LIMIT != 32'd0) && i_en &&
                    (r_count == LIMIT - 32'd1);
  assign o_count  = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en && !o_expire) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: rtl/test_status_device.sv
// tohost responder: decodes the result word, keeps a sticky verdict.
// Ports: clk, rst (async low), bus (slave), done/pass/timeout/fail_id/cycle_count.
module test_status_device
  import test_status_device_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TOHOST_DFLT,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000
) (
  input  logic                 clk,
  input  logic                 rst,
  test_status_device_if.slave  bus,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [30:0]          fail_id,
  output logic [31:0]          cycle_count
);

  localparam logic [31:0] STATUS_ADDR = TOHOST_ADDR + 32'd4;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_tohost, w_tohost_nxt;
  logic [30:0] r_fail_id, w_fail_id_nxt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata, w_rdata;
  logic        w_accept, w_run, w_expire;
  logic        w_hit_tohost, w_hit_status;
  logic        w_wr_tohost, w_term;
  logic [3:0]  w_status;
  logic        w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[1:0];

  assign bus.req_ready = 1'b1;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

  assign w_accept     = bus.req_valid && bus.req_ready;
  assign w_run        = (r_state == ST_RUN);
  assign w_hit_tohost = bus.req_addr[31:2] == TOHOST_ADDR[31:2];
  assign w_hit_status = bus.req_addr[31:2] == STATUS_ADDR[31:2];
  assign w_wr_tohost  = w_accept && bus.req_we && w_hit_tohost;
  assign w_term       = w_wr_tohost && w_run &&
                        (bus.req_wstrb == 4'hF) && bus.req_wdata[0];

  test_status_device_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_run),
    .o_expire (w_expire),
    .o_count  (cycle_count)
  );

  always_comb begin
    w_status                = '0;
    w_status[STAT_DONE]    = !w_run;
    w_status[STAT_PASS]    = (r_state == ST_PASS);
    w_status[STAT_FAIL]    = (r_state == ST_FAIL);
    w_status[STAT_TIMEOUT] = (r_state == ST_TIMEOUT);
  end

  // A terminating write beats a same-cycle watchdog expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_tohost_nxt  = r_tohost;
    w_fail_id_nxt = r_fail_id;
    if (w_run) begin
      if (w_term) begin
        w_tohost_nxt = bus.req_wdata;
        if (bus.req_wdata == PASS_CODE) begin
          w_state_nxt = ST_PASS;
        end else begin
          w_state_nxt   = ST_FAIL;
          w_fail_id_nxt = bus.req_wdata[31:1];
        end
      end else begin
        if (w_wr_tohost) begin
          for (int b = 0; b < 4; b++) begin
            if (bus.req_wstrb[b]) begin
              w_tohost_nxt[8*b +: 8] = bus.req_wdata[8*b +: 8];
            end
          end
        end
        if (w_expire) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (!bus.req_we) begin
      unique case (1'b1)
        w_hit_tohost: w_rdata = r_tohost;
        w_hit_status: w_rdata = {28'b0, w_status};
        default:      w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_tohost    <= '0;
      r_fail_id   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tohost    <= w_tohost_nxt;
      r_fail_id   <= w_fail_id_nxt;
      r_rsp_valid <= w_accept;
      r_rsp_rdata <= w_accept ? w_rdata : 32'h0;
    end
  end

  assign done    = !w_run;
  assign pass    = (r_state == ST_PASS);
  assign timeout = (r_state == ST_TIMEOUT);
  assign fail_id = r_fail_id;

endmodule

// File: tb/tb_test_status_device.sv
// Directed bench for test_status_device.
// Drives the bus interface and checks verdict pins and read data.
module tb_test_status_device;

  logic        clk;
  logic        rst;
  logic        done, pass, timeout;
  logic [30:0] fail_id;
  logic [31:0] cycle_count;
  logic        rv;
  logic [31:0] rd;
  int          n_chk;
  int          n_fail;

  test_status_device_if bus();

  test_status_device dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .fail_id     (fail_id),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic we,
                    input logic [31:0] addr,
                    input logic [31:0] wdata,
                    input logic [3:0] strb);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wstrb = strb;
    @(posedge clk);
    #1;
    rv = bus.rsp_valid;
    rd = bus.rsp_rdata;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic do_reset();
    bus.req_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_count(input logic [31:0] target);
    int budget;
    budget = 6000;
    while (cycle_count !== target && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    chk("wait_count", cycle_count, target);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    rst = 1'b0;
    #3;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("rst_rspv", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_pass", {31'b0, pass}, 32'h0);
    chk("rst_tmo", {31'b0, timeout}, 32'h0);
    chk("rst_failid", {1'b0, fail_id}, 32'h0);
    chk("rst_count", cycle_count, 32'h0);

    // pass at cycle 20
    do_reset();
    wait_count(32'd20);
    op(1'b1, 32'h1000, 32'h1, 4'hF);
    chk("p_rspv", {31'b0, rv}, 32'h1);
    chk("p_wrdata", rd, 32'h0);
    chk("p_done", {31'b0, done}, 32'h1);
    chk("p_pass", {31'b0, pass}, 32'h1);
    chk("p_count", cycle_count, 32'd21);
    op(1'b0, 32'h1004, 32'h0, 4'h0);
    chk("p_status", rd, 32'h3);
    repeat (5) @(posedge clk);
    #1;
    chk("p_frozen", cycle_count, 32'd21);

    // test 5 fails
    do_reset();
    op(1'b1, 32'h1000, 32'hB, 4'hF);
    chk("f_done", {31'b0, done}, 32'h1);
    chk("f_pass", {31'b0, pass}, 32'h0);
    chk("f_failid", {1'b0, fail_id}, 32'd5);
    op(1'b0, 32'h1004, 32'h0, 4'h0);
    chk("f_status", rd, 32'h5);
    op(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("f_tohost", rd, 32'hB);

    // non-terminating writes, other addresses
    do_reset();
    op(1'b1, 32'h1000, 32'h1, 4'h1);
    chk("n_done1", {31'b0, done}, 32'h0);
    op(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("n_rd1", rd, 32'h1);
    op(1'b1, 32'h1000, 32'h2, 4'hF);
    chk("n_done2", {31'b0, done}, 32'h0);
    op(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("n_rd2", rd, 32'h2);
    op(1'b1, 32'h1000, 32'hAABBCCDD, 4'h4);
    op(1'b0, 32'h1003, 32'h0, 4'h0);
    chk("n_bytelane", rd, 32'h00BB0002);
    op(1'b1, 32'h2000, 32'hFFFFFFFF, 4'hF);
    chk("n_oth_rspv", {31'b0, rv}, 32'h1);
    op(1'b0, 32'h2000, 32'h0, 4'h0);
    chk("n_oth_rd", rd, 32'h0);
    chk("n_oth_rspv2", {31'b0, rv}, 32'h1);
    op(1'b1, 32'h1004, 32'h1, 4'hF);
    op(1'b0, 32'h1004, 32'h0, 4'h0);
    chk("n_status", rd, 32'h0);

    // watchdog expiry
    wait_count(32'd4999);
    chk("t_pre", {31'b0, timeout}, 32'h0);
    @(posedge clk);
    #1;
    chk("t_tmo", {31'b0, timeout}, 32'h1);
    chk("t_done", {31'b0, done}, 32'h1);
    chk("t_count", cycle_count, 32'd4999);
    op(1'b0, 32'h1004, 32'h0, 4'h0);
    chk("t_status", rd, 32'h9);
    chk("t_count2", cycle_count, 32'd4999);

    // pass in the expiry cycle
    do_reset();
    wait_count(32'd4999);
    op(1'b1, 32'h1000, 32'h1, 4'hF);
    chk("e_pass", {31'b0, pass}, 32'h1);
    chk("e_tmo", {31'b0, timeout}, 32'h0);
    chk("e_done", {31'b0, done}, 32'h1);
    op(1'b1, 32'h1000, 32'h7, 4'hF);
    chk("e_rspv", {31'b0, rv}, 32'h1);
    chk("e_pass2", {31'b0, pass}, 32'h1);
    chk("e_failid", {1'b0, fail_id}, 32'h0);
    op(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("e_tohost", rd, 32'h1);
    @(posedge clk);
    #1;
    chk("e_tmo2", {31'b0, timeout}, 32'h0);

    // async reset with a response in flight
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    op(1'b0, 32'h1000, 32'h0, 4'h0);
    chk("r_rspv_pre", {31'b0, rv}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("r_rspv", {31'b0, bus.rsp_valid}, 32'h0);
    chk("r_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("r_count", cycle_count, 32'h0);
    chk("r_done", {31'b0, done}, 32'h0);
    @(posedge clk);
    #1;
    chk("r_count2", cycle_count, 32'h0);
    chk("r_rspv2", {31'b0, bus.rsp_valid}, 32'h0);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
